// File: rtl/peek_pkg.sv
// peek_pkg: shared types and constants for the peek_monitor debug display block.
package peek_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        SKIP = 2'd2
    } brk_state_t;

    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peek_monitor_hex7.sv
// Hex7: one hex nibble to an active-low seven-segment pattern, segment a at bit 0, g at bit 6.
module Hex7
    import peek_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: o_seg gets a value before the case so no path can leave it unassigned, which would infer a latch.
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/peek_monitor.sv
// peek_monitor: tap viewer with paging/auto-scroll/freeze, gated CPU step and step counter.
// Define PEEK_MONITOR_BREAK_EN to compile in the breakpoint FSM (RUN/HALT/SKIP).
module peek_monitor
    import peek_pkg::*;
#(
    parameter  int NUM_TAPS   = 16,
    parameter  int DATA_W     = 32,
    parameter  int NUM_DIGITS = 4,
    parameter  int CYCLE_W    = 8,
    parameter  int SCROLL_DIV = 25_000_000,
    localparam int SEL_W      = clog2_min1(NUM_TAPS),
    localparam int PAGE_W     = 4 * NUM_DIGITS,
    localparam int NUM_PAGES  = (DATA_W + PAGE_W - 1) / PAGE_W,
    localparam int PG_W       = clog2_min1(NUM_PAGES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       StepPulse,
    input  logic                       Peek,
    input  logic [SEL_W-1:0]           Sel,
    input  logic [PG_W-1:0]            PageSel,
    input  logic                       AutoScroll,
    input  logic                       Freeze,
    input  logic                       CountClr,
    input  logic                       Resume,
    input  logic                       BreakEn,
    input  logic [NUM_TAPS*DATA_W-1:0] TapBus,
    input  logic [DATA_W-1:0]          BreakAddr,
    output logic                       StepOut,
    output logic                       Halted,
    output logic [CYCLE_W-1:0]         CycleCount,
    output logic [PG_W-1:0]            PageIdx,
    output logic [NUM_DIGITS*7-1:0]    Seg
);

    localparam int               PAD_W     = NUM_PAGES * PAGE_W;
    localparam int               DIV_W     = clog2_min1(SCROLL_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
    localparam logic [PG_W-1:0]  PAGE_LAST = PG_W'(NUM_PAGES - 1);

    logic [DATA_W-1:0]  w_tap0;
    logic [DATA_W-1:0]  w_live;
    logic [DATA_W-1:0]  w_src;
    logic [PAD_W-1:0]   w_src_pad;
    logic [PG_W-1:0]    w_page_next;
    logic [DIV_W-1:0]   w_div_next;
    logic [PAGE_W-1:0]  w_nib_next;
    logic               w_accept;

    logic [DATA_W-1:0]  r_snap;
    logic               r_freeze_q;
    logic               r_auto_q;
    logic [PG_W-1:0]    r_page;
    logic [DIV_W-1:0]   r_div;
    logic [PAGE_W-1:0]  r_nib;
    logic               r_step_out;
    logic [CYCLE_W-1:0] r_count;

    assign w_tap0 = TapBus[DATA_W-1:0];

    always_comb begin
        w_live = w_tap0;
        if (Peek) begin
            if (32'(Sel) < NUM_TAPS) w_live = TapBus[Sel*DATA_W +: DATA_W];
            else                     w_live = '0;
        end
    end

    // The snapshot is captured on the edge where Freeze rises, so it only drives the display from the next cycle.
    assign w_src      = (Freeze && r_freeze_q) ? r_snap : w_live;
    assign w_src_pad  = PAD_W'(w_src);
    assign w_nib_next = w_src_pad[w_page_next*PAGE_W +: PAGE_W];

    always_comb begin
        w_page_next = r_page;
        w_div_next  = '0;
        if (AutoScroll) begin
            if (!r_auto_q) begin
                w_page_next = '0;
            end else if (r_div == DIV_LAST) begin
                w_page_next = (r_page == PAGE_LAST) ? '0 : r_page + 1'b1;
            end else begin
                w_div_next = r_div + 1'b1;
            end
        end else begin
            w_page_next = (32'(PageSel) >= NUM_PAGES) ? PAGE_LAST : PageSel;
        end
    end

    // Page index and nibbles load together so PageIdx always names the page on Seg.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_freeze_q <= 1'b0;
            r_auto_q   <= 1'b0;
            r_snap     <= '0;
            r_page     <= '0;
            r_div      <= '0;
            r_nib      <= '0;
        end else begin
            r_freeze_q <= Freeze;
            r_auto_q   <= AutoScroll;
            if (Freeze && !r_freeze_q) r_snap <= w_live;
            r_page     <= w_page_next;
            r_div      <= w_div_next;
            r_nib      <= w_nib_next;
        end
    end

`ifdef PEEK_MONITOR_BREAK_EN
    brk_state_t r_state;
    logic       r_halted;
    logic       w_match;

    assign w_match = BreakEn && (w_tap0 == BreakAddr);

    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            RUN:     w_accept = StepPulse && !w_match;
            SKIP:    w_accept = StepPulse;
            default: w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_halted   <= 1'b0;
            r_step_out <= 1'b0;
        end else begin
            r_step_out <= w_accept;
            case (r_state)
                RUN: if (StepPulse && w_match) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end
                HALT: if (Resume) begin
                    r_state  <= SKIP;
                    r_halted <= 1'b0;
                end
                SKIP: if (StepPulse) r_state <= RUN;
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign Halted = r_halted;
`else
    logic w_unused_brk;

    assign w_unused_brk = ^{BreakAddr, BreakEn, Resume};
    assign w_accept     = StepPulse;

    always_ff @(posedge clk) begin
        if (reset) r_step_out <= 1'b0;
        else       r_step_out <= w_accept;
    end

    assign Halted = 1'b0;
`endif

    // Counts on acceptance so CycleCount and StepOut change on the same edge; a clear wins.
    always_ff @(posedge clk) begin
        if (reset)         r_count <= '0;
        else if (CountClr) r_count <= '0;
        else if (w_accept) r_count <= r_count + 1'b1;
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        Hex7 u_hex7 (
            .i_nib (r_nib[d*4 +: 4]),
            .o_seg (Seg[d*7 +: 7])
        );
    end

    assign StepOut    = r_step_out;
    assign CycleCount = r_count;
    assign PageIdx    = r_page;

endmodule

// File: tb/tb_peek_monitor.sv
// tb_peek_monitor: scoreboard bench for peek_monitor (step gating, paging, scroll, freeze, counter).
module tb_peek_monitor;

`ifdef PEEK_MONITOR_BREAK_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         step_pulse = 1'b0;
    logic         peek = 1'b0;
    logic [3:0]   sel = '0;
    logic [0:0]   page_sel = '0;
    logic         auto_scroll = 1'b0;
    logic         freeze = 1'b0;
    logic         count_clr = 1'b0;
    logic         resume = 1'b0;
    logic         break_en = 1'b0;
    logic [511:0] tap_bus = '0;
    logic [31:0]  break_addr = '0;
    logic         step_out;
    logic         halted;
    logic [7:0]   cycle_count;
    logic [0:0]   page_idx;
    logic [27:0]  seg;

    peek_monitor #(
        .NUM_TAPS   (16),
        .DATA_W     (32),
        .NUM_DIGITS (4),
        .CYCLE_W    (8),
        .SCROLL_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .StepPulse  (step_pulse),
        .Peek       (peek),
        .Sel        (sel),
        .PageSel    (page_sel),
        .AutoScroll (auto_scroll),
        .Freeze     (freeze),
        .CountClr   (count_clr),
        .Resume     (resume),
        .BreakEn    (break_en),
        .TapBus     (tap_bus),
        .BreakAddr  (break_addr),
        .StepOut    (step_out),
        .Halted     (halted),
        .CycleCount (cycle_count),
        .PageIdx    (page_idx),
        .Seg        (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  cnt;
    } step_exp_t;

    typedef struct {
        string       tag;
        logic [27:0] seg;
    } disp_exp_t;

    step_exp_t   step_q[$];
    disp_exp_t   disp_q[$];
    int unsigned cyc = 0;
    logic [7:0]  exp_count = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Active-high gfedcba patterns, inverted for the active-low display.
    function automatic logic [6:0] seg_digit(input logic [3:0] n);
        case (n)
            4'h0: return ~7'h3F;  4'h1: return ~7'h06;  4'h2: return ~7'h5B;  4'h3: return ~7'h4F;
            4'h4: return ~7'h66;  4'h5: return ~7'h6D;  4'h6: return ~7'h7D;  4'h7: return ~7'h07;
            4'h8: return ~7'h7F;  4'h9: return ~7'h6F;  4'hA: return ~7'h77;  4'hB: return ~7'h7C;
            4'hC: return ~7'h39;  4'hD: return ~7'h5E;  4'hE: return ~7'h79;  default: return ~7'h71;
        endcase
    endfunction

    function automatic logic [27:0] seg_of(input logic [15:0] v);
        return {seg_digit(v[15:12]), seg_digit(v[11:8]), seg_digit(v[7:4]), seg_digit(v[3:0])};
    endfunction

    // Step scoreboard: every StepOut must match the oldest pending entry in cycle and count.
    always @(negedge clk) begin
        while (step_q.size() > 0 && step_q[0].cyc < cyc) begin
            check("step_missing_cyc", 64'(cyc), 64'(step_q[0].cyc));
            void'(step_q.pop_front());
        end
        if (step_out) begin
            if (step_q.size() == 0) begin
                check("unexpected_step", 64'(step_out), 64'd0);
            end else begin
                step_exp_t e;
                e = step_q.pop_front();
                check("step_latency", 64'(cyc), 64'(e.cyc));
                check("step_count", 64'(cycle_count), 64'(e.cnt));
            end
        end
    end

    task automatic do_step(input bit fwd, input bit clr);
        step_exp_t e;
        step_pulse = 1'b1;
        count_clr  = clr;
        if (fwd) begin
            exp_count = clr ? 8'd0 : exp_count + 8'd1;
            e.cyc = cyc + 1;
            e.cnt = exp_count;
            step_q.push_back(e);
        end
        @(negedge clk);
        step_pulse = 1'b0;
        count_clr  = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_disp(input string tag, input logic [15:0] v);
        disp_exp_t e;
        e.tag = tag;
        e.seg = seg_of(v);
        disp_q.push_back(e);
        @(negedge clk);
        e = disp_q.pop_front();
        check(e.tag, 64'(seg), 64'(e.seg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_stepout", 64'(step_out), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", 64'(cycle_count), 64'd0);
        check("rst_page", 64'(page_idx), 64'd0);
        check("rst_seg", 64'(seg), 64'(seg_of(16'h0000)));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0);
        check("count_after_3", 64'(cycle_count), 64'd3);

        tap_bus[31:0] = 32'h0000_0010;
        break_addr    = 32'h0000_0010;
        break_en      = 1'b1;
        @(negedge clk);
        do_step(!BRK, 1'b0);
        check("halt_on_match", 64'(halted), 64'(BRK));
        do_step(!BRK, 1'b0);
        check("halt_drops_step", 64'(halted), 64'(BRK));
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_leaves_halt", 64'(halted), 64'd0);
        do_step(1'b1, 1'b0);
        check("skip_forwards", 64'(halted), 64'd0);
        break_en = 1'b0;

        peek = 1'b1;
        sel  = 4'd5;
        tap_bus[5*32 +: 32] = 32'hDEAD_BEEF;
        page_sel = 1'b1;
        expect_disp("page1_dead", 16'hDEAD);
        check("page_idx_1", 64'(page_idx), 64'd1);
        page_sel = 1'b0;
        expect_disp("page0_beef", 16'hBEEF);
        peek = 1'b0;
        expect_disp("peek_low_tap0", 16'h0010);

        peek = 1'b1;
        sel  = 4'd1;
        tap_bus[1*32 +: 32] = 32'h0000_1234;
        expect_disp("live_1234", 16'h1234);
        freeze = 1'b1;
        expect_disp("freeze_rise", 16'h1234);
        tap_bus[1*32 +: 32] = 32'h0000_9999;
        sel = 4'd5;
        expect_disp("frozen_a", 16'h1234);
        expect_disp("frozen_b", 16'h1234);
        freeze = 1'b0;
        expect_disp("unfrozen", 16'hBEEF);

        auto_scroll = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check("scroll_page", 64'(page_idx), 64'((k / 4) % 2));
            check("scroll_seg", 64'(seg), 64'(((k / 4) % 2) ? seg_of(16'hDEAD) : seg_of(16'hBEEF)));
        end

        reset      = 1'b1;
        step_pulse = 1'b1;
        @(negedge clk);
        check("midscroll_rst_page", 64'(page_idx), 64'd0);
        check("midscroll_rst_stepout", 64'(step_out), 64'd0);
        check("midscroll_rst_count", 64'(cycle_count), 64'd0);
        check("midscroll_rst_seg", 64'(seg), 64'(seg_of(16'h0000)));
        reset       = 1'b0;
        step_pulse  = 1'b0;
        auto_scroll = 1'b0;
        exp_count   = '0;
        @(negedge clk);

        for (int i = 0; i < 255; i++) do_step(1'b1, 1'b0);
        check("count_ff", 64'(cycle_count), 64'hFF);
        do_step(1'b1, 1'b0);
        check("count_wrap", 64'(cycle_count), 64'd0);
        do_step(1'b1, 1'b0);
        do_step(1'b1, 1'b1);
        check("count_clr_wins", 64'(cycle_count), 64'd0);

        repeat (3) @(negedge clk);
        check("step_sb_empty", 64'(step_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peek_monitor.md
PEEK_MONITOR -- requirements
Module: peek_monitor

Interface
REQ-001 Parameter NUM_TAPS, default 16: number of DATA_W-bit tap channels; tap 0 is the PC.
REQ-002 Parameter DATA_W, default 32: tap width, a multiple of 4.
REQ-003 Parameter NUM_DIGITS, default 4: number of hex digits driven; PAGE_W = 4*NUM_DIGITS; NUM_PAGES = ceil(DATA_W/PAGE_W).
REQ-004 Parameter CYCLE_W, default 8: cycle counter width.
REQ-005 Parameter SCROLL_DIV, default 25_000_000: clk cycles per auto-scroll page advance.
REQ-006 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port StepPulse, input, 1: one-clk debounced step request.
REQ-009 Port Peek, input, 1: low forces tap 0 on the display.
REQ-010 Port Sel, input, $clog2(NUM_TAPS): tap select.
REQ-011 Port PageSel, input, $clog2(NUM_PAGES) (min 1): manual page select.
REQ-012 Port AutoScroll, Freeze, CountClr, Resume, BreakEn, inputs, 1 each: mode controls.
REQ-013 Port TapBus, input, NUM_TAPS*DATA_W: tap i at bits [i*DATA_W +: DATA_W].
REQ-014 Port BreakAddr, input, DATA_W: breakpoint PC.
REQ-015 Port StepOut, output, 1: gated step pulse to the CPU.
REQ-016 Port Halted, output, 1: breakpoint halt status.
REQ-017 Port CycleCount, output, CYCLE_W: count of forwarded steps.
REQ-018 Port PageIdx, output, $clog2(NUM_PAGES) (min 1): page currently shown.
REQ-019 Port Seg, output, NUM_DIGITS*7: active-low segments; digit d at bits [d*7 +: 7], digit 0 least significant.

Function
REQ-020 The source SHALL be tap 0 when Peek=0, else tap Sel; Sel>=NUM_TAPS SHALL yield zero.
REQ-021 In the cycle Freeze rises 0->1, the current source SHALL be captured into a snapshot; while Freeze=1 the display SHALL show the snapshot, and Sel/Peek changes SHALL have no effect until Freeze=0.
REQ-022 The displayed value SHALL be bits [PageIdx*PAGE_W +: PAGE_W] of the source, zero-extended where the slice passes DATA_W.
REQ-023 With AutoScroll=0, PageIdx SHALL follow PageSel, with values >=NUM_PAGES clamped to NUM_PAGES-1.
REQ-024 With AutoScroll=1, a divider SHALL advance PageIdx every SCROLL_DIV cycles and wrap from NUM_PAGES-1 to 0; on AutoScroll rising the divider SHALL clear and PageIdx SHALL start at 0.
REQ-025 The display nibbles SHALL be registered, so Seg reflects a source or page change one clk later.
REQ-026 StepOut SHALL be a one-clk pulse registered one clk after an accepted StepPulse.
REQ-027 Breakpoint FSM states: RUN, HALT, SKIP.
REQ-028 RUN: a StepPulse SHALL be forwarded unless BreakEn=1 and tap0==BreakAddr; in that case it SHALL be dropped and the FSM SHALL go to HALT.
REQ-029 HALT: StepPulse SHALL be dropped; Resume=1 SHALL move the FSM to SKIP.
REQ-030 SKIP: the next StepPulse SHALL be forwarded regardless of the match, and the FSM SHALL return to RUN.
REQ-031 If Resume and StepPulse coincide in HALT, the step SHALL be dropped and the FSM SHALL enter SKIP.
REQ-032 Halted SHALL be 1 exactly in HALT.
REQ-033 CycleCount SHALL increment on each StepOut and wrap from all-ones to 0; CountClr SHALL win over a simultaneous increment.

Reset
REQ-034 Reset SHALL set the FSM to RUN and clear StepOut, Halted, CycleCount, PageIdx, the divider, the snapshot and the display registers, so Seg shows all "0".
REQ-035 Reset asserted mid-halt or mid-scroll SHALL take effect on the next clk edge, with no StepOut pulse emitted.

Configuration
REQ-036 With macro PEEK_MONITOR_BREAK_EN defined, the breakpoint FSM (REQ-027..032) SHALL be compiled in.
REQ-037 Without PEEK_MONITOR_BREAK_EN, every StepPulse SHALL be forwarded per REQ-026, Halted SHALL be tied 0, and BreakAddr, BreakEn and Resume SHALL be ignored.

Structure
REQ-038 Package peek_pkg SHALL hold the FSM state enum (RUN, HALT, SKIP) and the active-low segment constant for blank.
REQ-039 Each digit SHALL be encoded by one instance of the existing Hex7 sub-module in a generate loop; there SHALL be no other sub-modules.

Verification
REQ-040 Reset, then 3 StepPulses with BreakEn=0 -> three StepOut pulses, each 1 clk after its StepPulse; CycleCount=3.
REQ-041 Tap0=0x0000_0010, BreakAddr=0x10, BreakEn=1, StepPulse -> no StepOut, Halted=1; StepPulse again -> dropped; Resume then StepPulse -> StepOut, Halted=0.
REQ-042 Peek=1, Sel=5, tap5=0xDEAD_BEEF, PageSel=1 -> Seg shows "DEAD" one clk later; PageSel=0 -> "BEEF".
REQ-043 SCROLL_DIV=4, AutoScroll=1 -> PageIdx sequence 0,1,0 at 4-clk intervals.
REQ-044 Freeze rises with Sel=1, tap1=0x1234; tap1 then changes to 0x9999 -> display holds "1234" until Freeze=0.
REQ-045 CycleCount=0xFF, StepPulse -> 0x00; CountClr together with StepPulse -> 0x00 and StepOut still emitted.
